// File: rtl/fifo_arb_pkg.sv
// Types and defaults for the FIFO write-side arbiter.
package fifo_arb_pkg;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        STALL = 2'd2
    } arb_state_e;

endpackage

// File: rtl/fifo_pkg.sv
// Shared FIFO constants used by every block that talks to the write-side FIFO.
package fifo_pkg;

    localparam int FIFO_WIDTH = 16;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority rotate: first set request after position 'last', wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   index
);

    logic found;
    int   cand;

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        onehot = '0;
        index  = '0;
        found  = 1'b0;
        cand   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last) + k) % NUM_REQ;
            if (!found && req[cand]) begin
                found        = 1'b1;
                onehot[cand] = 1'b1;
                index        = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers,
// with full/almostfull throttling, a registered write stage and saturating statistics.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int FIFO_WIDTH = fifo_pkg::FIFO_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_wr_ack,
    output logic [1:0]                    state,
    output logic [CNT_WIDTH-1:0]          grant_cnt,
    output logic [CNT_WIDTH-1:0]          drop_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    pick_onehot;
    logic [IDX_W-1:0]      win_idx;
    logic [IDX_W-1:0]      last_q, last_d;
    logic [FIFO_WIDTH-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0]  grant_cnt_q, grant_cnt_d;
    logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
    arb_state_e            state_q, state_d;
    logic                  wr_en_q, wr_pend_q;
    logic                  blocked, granted;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .last   (last_q),
        .onehot (pick_onehot),
        .index  (win_idx)
    );

    // An almostfull FIFO with a write already in flight is effectively full.
    assign blocked = fifo_full | (fifo_almostfull & wr_en_q);
    assign gnt     = (rst || blocked) ? '0 : pick_onehot;
    assign granted = |gnt;

    always_comb begin
        last_d      = last_q;
        data_d      = data_q;
        grant_cnt_d = grant_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (granted) begin
            last_d = win_idx;
            data_d = req_data[int'(win_idx)*FIFO_WIDTH +: FIFO_WIDTH];
            if (~&grant_cnt_q) grant_cnt_d = grant_cnt_q + CNT_WIDTH'(1);
        end
        if (wr_pend_q && !fifo_wr_ack && ~&drop_cnt_q) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);

        if (granted)      state_d = GRANT;
        else if (|req)    state_d = STALL;
        else              state_d = IDLE;
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q     <= 1'b0;
            wr_pend_q   <= 1'b0;
            data_q      <= '0;
            last_q      <= IDX_W'(NUM_REQ - 1);
            state_q     <= IDLE;
            grant_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            wr_en_q     <= granted;
            wr_pend_q   <= wr_en_q;
            data_q      <= data_d;
            last_q      <= last_d;
            state_q     <= state_d;
            grant_cnt_q <= grant_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_data_in = data_q;
    assign state        = state_q;
    assign grant_cnt    = grant_cnt_q;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a depth-8 FIFO model drives the flags,
// and a scoreboard queue checks every registered write word in order.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int FW = 16;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req = '0;
    logic [NR*FW-1:0] req_data = '0;
    logic [NR-1:0]   gnt;
    logic            fifo_wr_en;
    logic [FW-1:0]   fifo_data_in;
    logic            fifo_full, fifo_almostfull;
    logic            fifo_wr_ack = 1'b0;
    logic [1:0]      state;
    logic [CW-1:0]   grant_cnt, drop_cnt;

    // FIFO model controls and state
    int   fcount = 0;
    logic fifo_rd = 1'b0;
    logic fifo_flush = 1'b0;
    logic nack_force = 1'b0;
    logic overflow = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [FW-1:0] sb_q[$];

    fifo_wr_arbiter #(.NUM_REQ(NR), .FIFO_WIDTH(FW), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .req_data        (req_data),
        .gnt             (gnt),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_data_in    (fifo_data_in),
        .fifo_full       (fifo_full),
        .fifo_almostfull (fifo_almostfull),
        .fifo_wr_ack     (fifo_wr_ack),
        .state           (state),
        .grant_cnt       (grant_cnt),
        .drop_cnt        (drop_cnt)
    );

    always #5 clk = ~clk;

    assign fifo_full       = (fcount == 8);
    assign fifo_almostfull = (fcount == 7);

    always @(posedge clk) begin
        if (fifo_flush) fcount <= 0;
        else fcount <= fcount + ((fifo_wr_en && !fifo_full) ? 1 : 0)
                              - ((fifo_rd && fcount > 0) ? 1 : 0);
        if (fifo_wr_en === 1'b1 && fifo_full) overflow <= 1'b1;
        fifo_wr_ack <= (fifo_wr_en === 1'b1) && !fifo_full && !nack_force;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every registered write must match the oldest expected word.
    always @(negedge clk) begin
        if (fifo_wr_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr_unexpected: got data 0x%0h expected no write at %0t", fifo_data_in, $time);
            end else begin
                check("wr_data", 32'(fifo_data_in), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic set_lane(input int i, input logic [FW-1:0] v);
        req_data[i*FW +: FW] = v;
    endtask

    task automatic flush();
        fifo_flush = 1'b1;
        step();
        fifo_flush = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NR-1:0] exp_gnt1 [5];
        exp_gnt1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset state, gnt forced low while rst is high
        repeat (3) step();
        req = 4'b1111;
        for (int i = 0; i < NR; i++) set_lane(i, FW'(16'h00A0 + i));
        settle();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_wr_en", 32'(fifo_wr_en), 0);
        check("rst_data", 32'(fifo_data_in), 0);
        check("rst_state", 32'(state), 0);
        check("rst_grant_cnt", 32'(grant_cnt), 0);
        check("rst_drop_cnt", 32'(drop_cnt), 0);

        // Round-robin over all four requesters
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            settle();
            check("rr_gnt", 32'(gnt), 32'(exp_gnt1[i]));
            sb_q.push_back(FW'(16'h00A0 + (i % 4)));
        end
        step();
        req = '0;
        settle();
        check("rr_idle_gnt", 32'(gnt), 0);
        check("rr_grant_cnt", 32'(grant_cnt), 5);
        check("rr_state_grant", 32'(state), 1);
        step();
        settle();
        check("rr_state_idle", 32'(state), 0);
        check("rr_drop_cnt", 32'(drop_cnt), 0);
        flush();

        // Single requester held for three cycles
        for (int k = 0; k < 3; k++) begin
            step();
            req = 4'b0100;
            set_lane(2, FW'(16'h00B0 + k));
            settle();
            check("single_gnt", 32'(gnt), 32'(4'b0100));
            sb_q.push_back(FW'(16'h00B0 + k));
            if (k > 0) begin
                check("single_wr_en", 32'(fifo_wr_en), 1);
                check("single_state", 32'(state), 1);
            end
        end
        step();
        req = '0;
        settle();
        check("single_wr_en_last", 32'(fifo_wr_en), 1);
        step();
        step();
        flush();

        // Fill a depth-8 FIFO with no reads: exactly 8 grants then stall
        for (int i = 0; i < 11; i++) begin
            step();
            req = 4'b0001;
            if (i < 8) set_lane(0, FW'(16'h00C0 + i));
            settle();
            check("fill_gnt", 32'(gnt), (i < 8) ? 32'h1 : 32'h0);
            if (i < 8) sb_q.push_back(FW'(16'h00C0 + i));
            if (i == 8) begin
                check("fill_af_inflight", 32'({fifo_almostfull, fifo_wr_en}), 32'h3);
            end
            if (i == 9) check("fill_state_stall", 32'(state), 2);
        end
        check("fill_overflow", 32'(overflow), 0);
        check("fill_drop_cnt", 32'(drop_cnt), 0);

        // One read pulse on a full FIFO lets exactly one grant through
        step();
        fifo_rd = 1'b1;
        set_lane(0, 16'h00D0);
        settle();
        check("rd_same_cycle_gnt", 32'(gnt), 0);
        step();
        fifo_rd = 1'b0;
        settle();
        check("rd_one_gnt", 32'(gnt), 32'h1);
        sb_q.push_back(16'h00D0);
        step();
        settle();
        check("rd_blocked_gnt", 32'(gnt), 0);
        check("rd_state_grant", 32'(state), 1);
        step();
        settle();
        check("rd_blocked_gnt2", 32'(gnt), 0);
        check("rd_state_stall", 32'(state), 2);
        check("rd_grant_cnt", 32'(grant_cnt), 17);
        check("rd_overflow", 32'(overflow), 0);
        req = '0;
        step();
        step();
        flush();

        // Missing write acknowledge counts one drop a cycle later
        step();
        req = 4'b0010;
        set_lane(1, 16'h00E1);
        settle();
        check("nack_gnt", 32'(gnt), 32'(4'b0010));
        sb_q.push_back(16'h00E1);
        step();
        req = '0;
        nack_force = 1'b1;
        settle();
        check("nack_wr_en", 32'(fifo_wr_en), 1);
        step();
        nack_force = 1'b0;
        settle();
        check("nack_drop_before", 32'(drop_cnt), 0);
        step();
        settle();
        check("nack_drop_after", 32'(drop_cnt), 1);
        step();
        flush();

        // Reset while a write is in flight
        step();
        req = 4'b1111;
        for (int i = 0; i < NR; i++) set_lane(i, FW'(16'h00F0 + i));
        settle();
        check("mid_gnt", 32'(gnt), 32'(4'b0100));
        sb_q.push_back(16'h00F2);
        step();
        rst = 1'b1;
        nack_force = 1'b1;
        settle();
        check("mid_rst_gnt", 32'(gnt), 0);
        step();
        rst = 1'b0;
        nack_force = 1'b0;
        settle();
        check("mid_wr_en", 32'(fifo_wr_en), 0);
        check("mid_data", 32'(fifo_data_in), 0);
        check("mid_grant_cnt", 32'(grant_cnt), 0);
        check("mid_drop_cnt", 32'(drop_cnt), 0);
        check("mid_state", 32'(state), 0);
        check("mid_first_gnt", 32'(gnt), 32'h1);
        sb_q.push_back(16'h00F0);
        step();
        req = '0;
        settle();
        check("mid_wr_en_after", 32'(fifo_wr_en), 1);
        step();
        settle();
        check("mid_no_drop", 32'(drop_cnt), 0);
        check("mid_grant_cnt_after", 32'(grant_cnt), 1);

        step();
        step();
        check("sb_empty", 32'(sb_q.size()), 0);
        check("end_overflow", 32'(overflow), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-side arbiter that lets NUM_REQ producers share a single FIFO write port.
- Accepts one requester word per cycle with a same-cycle grant (valid/ready style).
- Drives the FIFO's wr_en and data_in from registers, one cycle after acceptance.
- Throttles grants from the FIFO's full and almostfull flags so this block never causes an overflow.
- Counts accepted and dropped writes for the scoreboard and coverage.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
FIFO_WIDTH, 16, data word width; must match the FIFO
CNT_WIDTH, 16, width of the statistics counters (saturating)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester valid
req_data  in  NUM_REQ*FIFO_WIDTH  packed words; requester i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH]
gnt  out  NUM_REQ  one-hot combinational accept; a transfer happens when req[i] and gnt[i] are both high
fifo_wr_en  out  1  registered write enable to the FIFO
fifo_data_in  out  FIFO_WIDTH  registered write data
fifo_full  in  1  FIFO full flag
fifo_almostfull  in  1  FIFO almostfull flag (count = depth-1)
fifo_wr_ack  in  1  FIFO write acknowledge; registered, valid the cycle after wr_en
state  out  2  0 IDLE, 1 GRANT, 2 STALL (registered)
grant_cnt  out  CNT_WIDTH  number of accepted words
drop_cnt  out  CNT_WIDTH  number of writes not acknowledged by the FIFO

Behaviour:
Interface:
- One clock; reset is synchronous and active-high.

Reset (rst high at a clk edge):
- fifo_wr_en=0, fifo_data_in=0, state=IDLE, grant_cnt=0, drop_cnt=0.
- Round-robin pointer last=NUM_REQ-1, so requester 0 wins first after reset.
- gnt is forced to 0 combinationally while rst is high.

Blocking:
- blocked = fifo_full | (fifo_almostfull & fifo_wr_en).
- The second term covers the write already in flight.

Arbitration (combinational, each cycle):
- If !blocked and req != 0, the winner w is the first set req bit searching last+1, last+2, ... modulo NUM_REQ.
- gnt = onehot(w); otherwise gnt = 0.
- At most one gnt bit is ever high.

Registered datapath:
- fifo_wr_en <= |gnt.
- fifo_data_in <= req_data[w] when granted; it holds its previous value otherwise.
- Write latency is exactly 1 cycle from acceptance to fifo_wr_en.

Pointer:
- last <= w on a grant; unchanged otherwise.
- A requester that keeps req high therefore gets at most 1 of every NUM_REQ grants while others are requesting.

Requester rules:
- req_data[i] must be stable while req[i] is high and gnt[i] is low.
- The requester may present a new word in the cycle after the accept.
- The arbiter never withdraws a gnt mid-cycle.

FSM (registered, next state from the current cycle's inputs):
- IDLE: req=0.
- GRANT: a grant was issued.
- STALL: req!=0 and blocked.
- Transitions are direct between any pair of states.

Drop tracking:
- wr_pend <= fifo_wr_en.
- If wr_pend & !fifo_wr_ack, drop_cnt increments (a FIFO-side overflow or an external write collision).

Counters:
- grant_cnt increments on every grant.
- Both counters saturate at all-ones.

Simultaneous events:
- A FIFO read in the same cycle does not unblock the arbiter; it is conservative by one cycle.

Reset mid-operation:
- An in-flight fifo_wr_en is cancelled on the next edge.
- No drop is counted for it, because wr_pend is cleared.

Decomposition:
fifo_arb_pkg:
- arb_state_e enum (IDLE, GRANT, STALL).
- Default NUM_REQ and CNT_WIDTH constants.
- Import alongside the existing shared FIFO package; FIFO_WIDTH comes from there.

Sub-module rr_pick:
- Parameterised NUM_REQ.
- Inputs req and last; outputs onehot and index.
- Pure combinational priority rotate; reusable for a future read-side arbiter.

The top level holds the registers, FSM and counters.

Test Plan:
- Reset release, req=4'b1111 with data 0xA0..0xA3, FIFO empty -> gnt order 0,1,2,3,0; fifo_data_in sequence A0,A1,A2,A3,A0, each 1 cycle after its gnt; grant_cnt=5.
- req=4'b0100 only, held for 3 cycles -> gnt=4'b0100 on every cycle; state=GRANT; fifo_wr_en high for 3 consecutive cycles.
- Depth-8 FIFO with no reads, req=4'b0001 continuously -> exactly 8 grants; gnt=0 once almostfull and wr_en coincide; state=STALL; FIFO overflow never asserted; drop_cnt=0.
- Full FIFO, then a single read pulse -> fifo_full drops and exactly one grant follows; state returns to STALL.
- Force fifo_wr_ack=0 on the cycle after a write -> drop_cnt increments by 1 one cycle later.
- rst asserted in the same cycle as a grant -> next cycle fifo_wr_en=0, counters=0, state=IDLE; the first grant after reset goes to req 0.
